alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL use these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept an instruction this cycle.
- in_ctrl  in  5  ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 sra, 8 lo-byte load, 9 hi-byte load).
- in_rs_a, in_rs_b  in  4  source register indices.
- in_rd  in  4  destination register index.
- in_a, in_b  in  16  register-file read data.
- in_imm  in  16  immediate.
- in_use_imm  in  1  when 1, operand B is in_imm, not forwarded.
- flush  in  1  kill the instruction held in S1.
- wb_en, wb_rd, wb_data  in  1/4/16  writeback port, used as a forwarding source.
- alu_a, alu_b  out  16  operands to the combinational ALU.
- alu_ctrl  out  5  opcode to the ALU.
- alu_out  in  16  ALU result.
- alu_ovfl  in  1  ALU overflow.
- out_valid  out  1  result register valid.
- out_ready  in  1  downstream accepts the result.
- out_rd  out  4  destination of the result.
- out_data  out  16  registered result.
- out_ovfl  out  1  registered overflow.
- ovfl_sticky  out  1  accumulated overflow flag.
- ovfl_clr  in  1  clear ovfl_sticky.
REQ-002 Reset SHALL be asynchronous, active-low, named rst_n; clock SHALL be clk; no other clock or reset SHALL exist.

Function
REQ-003 The block SHALL be a two-entry pipeline: S1 (operand register) feeds the ALU; S2 (result register) drives the out_* ports.
REQ-004 S1 SHALL capture in_ctrl, in_rs_a, in_rs_b, in_rd, in_a, in_b, in_imm and in_use_imm on an edge where in_valid && in_ready && !flush.
REQ-005 Advance (adv) SHALL be s1_valid && (!out_valid || out_ready); in_ready SHALL be !s1_valid || adv.
REQ-006 On adv, S2 SHALL load out_data=alu_out, out_ovfl=alu_ovfl, out_rd=S1 rd, and set out_valid=1.
REQ-007 When out_valid && out_ready && !adv, out_valid SHALL clear; when out_valid && !out_ready, S2 SHALL hold all values.
REQ-008 Latency SHALL be 2 edges from input handshake to out_valid=1 when no stall occurs; throughput SHALL be one instruction per cycle.
REQ-009 alu_ctrl SHALL equal the S1 ctrl; alu_a and alu_b SHALL be forwarded combinationally from S1 every cycle.
REQ-010 Forwarding for operand X (A or B) with index rs SHALL use this priority:
- S2 out_data, if out_valid && out_rd==rs;
- else wb_data, if wb_en && wb_rd==rs;
- else the S1 captured register value.
REQ-011 Index 0 SHALL never be forwarded; it always uses the captured value.
REQ-012 If in_use_imm=1, alu_b SHALL be the captured in_imm regardless of forwarding.
REQ-013 flush SHALL clear s1_valid at the next edge, suppress adv and input capture that cycle, and leave S2 untouched.
REQ-014 ovfl_sticky SHALL set on an adv edge with alu_ovfl=1 and clear on ovfl_clr=1; set SHALL win when both occur on the same edge.
REQ-015 Opcodes 7 and 10-31 SHALL pass through; the result is 0 with ovfl 0, as produced by the ALU.
REQ-016 While S1 is empty, alu_a, alu_b and alu_ctrl SHALL be 0.

Reset
REQ-017 While rst_n=0, the following SHALL be 0 immediately and with no clock: s1_valid, out_valid, out_data, out_ovfl, out_rd, ovfl_sticky. in_ready SHALL be 1.
REQ-018 If reset is asserted mid-operation, in-flight instructions SHALL be discarded and not replayed; the first edge after rst_n rises SHALL be able to accept input.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Overflow and sticky: in_a=0x7FFF, in_b=0x0001, ctrl 0, out_ready=1 -> two edges later out_valid=1, out_data=0x8000, out_ovfl=1, ovfl_sticky=1.
- S2 forwarding: back-to-back r3=r1+r2 (5+7), then r4=r3-r1 with stale in_a=0 -> second result 0x0007 (forwarded from S2).
- Backpressure: out_ready=0 for 3 cycles with 2 instructions issued -> in_ready=0 after S1 fills, out_data holds the first result, no loss or duplication after release.
- Flush and zero register: flush with S1 full -> that result never appears; forwarding with rs=0 and wb_rd=0, wb_en=1 -> the captured value is used.
- Reset and clear priority: rst_n low mid-stream -> out_valid=0 asynchronously. ovfl_clr=1 on the same edge as an overflowing adv -> ovfl_sticky=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Two-entry ALU issue pipeline: S1 holds operands and drives an external
// combinational ALU with forwarded values, S2 registers the result downstream.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_ctrl,
  input  logic [3:0]  in_rs_a,
  input  logic [3:0]  in_rs_b,
  input  logic [3:0]  in_rd,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_imm,
  input  logic        in_use_imm,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_rd,
  input  logic [15:0] wb_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_ctrl,
  input  logic [15:0] alu_out,
  input  logic        alu_ovfl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_rd,
  output logic [15:0] out_data,
  output logic        out_ovfl,
  output logic        ovfl_sticky,
  input  logic        ovfl_clr
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and a held valid keeps its data stable.
  logic        s1_valid;
  logic [4:0]  s1_ctrl;
  logic [3:0]  s1_rs_a;
  logic [3:0]  s1_rs_b;
  logic [3:0]  s1_rd;
  logic [15:0] s1_a;
  logic [15:0] s1_b;
  logic [15:0] s1_imm;
  logic        s1_use_imm;

  logic        adv;
  logic        capture;
  logic [15:0] opnd_a;
  logic [15:0] opnd_b;

  assign adv      = s1_valid && (!out_valid || out_ready) && !flush;
  assign in_ready = !s1_valid || adv;
  assign capture  = in_valid && in_ready && !flush;

  // Youngest producer wins: S2 result, then writeback, then the captured read.
  always_comb begin
    opnd_a = s1_a;
    if (s1_rs_a != 4'd0 && out_valid && out_rd == s1_rs_a) begin
      opnd_a = out_data;
    end else if (s1_rs_a != 4'd0 && wb_en && wb_rd == s1_rs_a) begin
      opnd_a = wb_data;
    end
    opnd_b = s1_b;
    if (s1_rs_b != 4'd0 && out_valid && out_rd == s1_rs_b) begin
      opnd_b = out_data;
    end else if (s1_rs_b != 4'd0 && wb_en && wb_rd == s1_rs_b) begin
      opnd_b = wb_data;
    end
  end

  assign alu_a    = s1_valid ? opnd_a : 16'd0;
  assign alu_b    = s1_valid ? (s1_use_imm ? s1_imm : opnd_b) : 16'd0;
  assign alu_ctrl = s1_valid ? s1_ctrl : 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_ctrl    <= 5'd0;
      s1_rs_a    <= 4'd0;
      s1_rs_b    <= 4'd0;
      s1_rd      <= 4'd0;
      s1_a       <= 16'd0;
      s1_b       <= 16'd0;
      s1_imm     <= 16'd0;
      s1_use_imm <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (capture) begin
      s1_valid   <= 1'b1;
      s1_ctrl    <= in_ctrl;
      s1_rs_a    <= in_rs_a;
      s1_rs_b    <= in_rs_b;
      s1_rd      <= in_rd;
      s1_a       <= in_a;
      s1_b       <= in_b;
      s1_imm     <= in_imm;
      s1_use_imm <= in_use_imm;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'd0;
      out_ovfl  <= 1'b0;
      out_rd    <= 4'd0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_data  <= alu_out;
      out_ovfl  <= alu_ovfl;
      out_rd    <= s1_rd;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A new overflow outranks a same-edge clear so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl_sticky <= 1'b0;
    end else if (adv && alu_ovfl) begin
      ovfl_sticky <= 1'b1;
    end else if (ovfl_clr) begin
      ovfl_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: models the external ALU, runs directed vectors and
// sequences, then random traffic checked cycle by cycle against a queue model.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_ctrl;
  logic [3:0]  in_rs_a, in_rs_b, in_rd;
  logic [15:0] in_a, in_b, in_imm;
  logic        in_use_imm, flush;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_ctrl;
  logic        alu_ovfl;
  logic        out_valid, out_ready;
  logic [3:0]  out_rd;
  logic [15:0] out_data;
  logic        out_ovfl, ovfl_sticky, ovfl_clr;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_ovfl(alu_ovfl),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_ovfl(out_ovfl),
    .ovfl_sticky(ovfl_sticky), .ovfl_clr(ovfl_clr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model: returns {ovfl, result} ----------------
  function automatic logic [16:0] alu_fn(input logic [4:0] c, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic        o;
    r = 16'd0;
    o = 1'b0;
    case (c)
      5'd0: begin r = a + b; o = (a[15] == b[15]) && (r[15] != a[15]); end
      5'd1: begin r = a - b; o = (a[15] != b[15]) && (r[15] != a[15]); end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = a << b[3:0];
      5'd6: r = $signed(a) >>> b[3:0];
      5'd8: r = {a[15:8], b[7:0]};
      5'd9: r = {b[7:0], a[7:0]};
      default: r = 16'd0;
    endcase
    return {o, r};
  endfunction

  assign {alu_ovfl, alu_out} = alu_fn(alu_ctrl, alu_a, alu_b);

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [3:0]  rs_a, rs_b, rd;
    logic [15:0] a, b, imm;
    logic        use_imm;
  } instr_t;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
    logic        ovfl;
  } res_t;

  // Reference pipeline: one queue slot per stage, at most one entry each.
  instr_t m_s1[$];
  res_t   m_s2[$];
  logic   m_sticky;

  function automatic logic [15:0] m_fwd(input logic [3:0] rs, input logic [15:0] cap);
    if (rs != 4'd0 && m_s2.size() != 0 && m_s2[0].rd == rs) return m_s2[0].data;
    if (rs != 4'd0 && wb_en && wb_rd == rs) return wb_data;
    return cap;
  endfunction

  function automatic logic [15:0] m_op_a();
    if (m_s1.size() == 0) return 16'd0;
    return m_fwd(m_s1[0].rs_a, m_s1[0].a);
  endfunction

  function automatic logic [15:0] m_op_b();
    if (m_s1.size() == 0) return 16'd0;
    if (m_s1[0].use_imm) return m_s1[0].imm;
    return m_fwd(m_s1[0].rs_b, m_s1[0].b);
  endfunction

  function automatic logic [4:0] m_ctrl();
    if (m_s1.size() == 0) return 5'd0;
    return m_s1[0].ctrl;
  endfunction

  function automatic logic m_adv();
    return (m_s1.size() != 0) && (m_s2.size() == 0 || out_ready) && !flush;
  endfunction

  function automatic logic m_in_ready();
    return (m_s1.size() == 0) || m_adv();
  endfunction

  task automatic model_reset();
    m_s1.delete();
    m_s2.delete();
    m_sticky = 1'b0;
  endtask

  task automatic model_edge();
    logic        adv, inr;
    logic [16:0] r;
    instr_t      ni;
    res_t        nr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    adv = m_adv();
    inr = m_in_ready();
    r   = alu_fn(m_ctrl(), m_op_a(), m_op_b());
    if (adv && r[16]) m_sticky = 1'b1;
    else if (ovfl_clr) m_sticky = 1'b0;
    if (adv) begin
      nr.rd   = m_s1[0].rd;
      nr.data = r[15:0];
      nr.ovfl = r[16];
      m_s2.delete();
      m_s2.push_back(nr);
    end else if (m_s2.size() != 0 && out_ready) begin
      m_s2.delete();
    end
    if (flush) begin
      m_s1.delete();
    end else if (in_valid && inr) begin
      ni.ctrl = in_ctrl; ni.rs_a = in_rs_a; ni.rs_b = in_rs_b; ni.rd = in_rd;
      ni.a = in_a; ni.b = in_b; ni.imm = in_imm; ni.use_imm = in_use_imm;
      m_s1.delete();
      m_s1.push_back(ni);
    end else if (adv) begin
      m_s1.delete();
    end
  endtask

  task automatic model_check();
    chk("in_ready", 16'(in_ready), 16'(m_in_ready()));
    chk("out_valid", 16'(out_valid), 16'(m_s2.size() != 0));
    chk("ovfl_sticky", 16'(ovfl_sticky), 16'(m_sticky));
    chk("alu_ctrl", 16'(alu_ctrl), 16'(m_ctrl()));
    chk("alu_a", alu_a, m_op_a());
    chk("alu_b", alu_b, m_op_b());
    if (m_s2.size() != 0) begin
      chk("out_data", out_data, m_s2[0].data);
      chk("out_rd", 16'(out_rd), 16'(m_s2[0].rd));
      chk("out_ovfl", 16'(out_ovfl), 16'(m_s2[0].ovfl));
    end
    if (!rst_n) begin
      chk("rst_out_data", out_data, 16'd0);
      chk("rst_out_rd", 16'(out_rd), 16'd0);
      chk("rst_out_ovfl", 16'(out_ovfl), 16'd0);
    end
  endtask

  // Model advances on each rising edge; outputs are compared 2 time units later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_edge();
      #2;
      if (!rst_n) model_reset();
      model_check();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] c, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rd, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic ui);
    in_valid = 1'b1; in_ctrl = c; in_rs_a = ra; in_rs_b = rb; in_rd = rd;
    in_a = a; in_b = b; in_imm = imm; in_use_imm = ui;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    flush = 1'b0; ovfl_clr = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  ctrl;
    logic [15:0] a, b, imm;
    logic        use_imm;
    logic [15:0] exp_data;
    logic        exp_ovfl;
  } vec_t;

  vec_t tbl[13];

  // ---------------- stimulus ----------------
  initial begin
    tbl[0]  = '{5'd0,  16'h1234, 16'h1111, 16'h0000, 1'b0, 16'h2345, 1'b0};
    tbl[1]  = '{5'd1,  16'h0005, 16'h0007, 16'h0000, 1'b0, 16'hFFFE, 1'b0};
    tbl[2]  = '{5'd1,  16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h7FFF, 1'b1};
    tbl[3]  = '{5'd2,  16'hF0F0, 16'h3C3C, 16'h0000, 1'b0, 16'h3030, 1'b0};
    tbl[4]  = '{5'd3,  16'hF000, 16'h000F, 16'h0000, 1'b0, 16'hF00F, 1'b0};
    tbl[5]  = '{5'd4,  16'hFFFF, 16'h1234, 16'h0000, 1'b0, 16'hEDCB, 1'b0};
    tbl[6]  = '{5'd5,  16'h0003, 16'h0004, 16'h0000, 1'b0, 16'h0030, 1'b0};
    tbl[7]  = '{5'd6,  16'h8000, 16'h0003, 16'h0000, 1'b0, 16'hF000, 1'b0};
    tbl[8]  = '{5'd0,  16'h0100, 16'hDEAD, 16'h0023, 1'b1, 16'h0123, 1'b0};
    tbl[9]  = '{5'd8,  16'hAB12, 16'h34CD, 16'h0000, 1'b0, 16'hABCD, 1'b0};
    tbl[10] = '{5'd9,  16'h0012, 16'h0077, 16'h0000, 1'b0, 16'h7712, 1'b0};
    tbl[11] = '{5'd7,  16'h1234, 16'h5678, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{5'd0,  16'h8000, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = 5'd0; in_rs_a = 4'd0; in_rs_b = 4'd0;
    in_rd = 4'd0; in_a = 16'd0; in_b = 16'd0; in_imm = 16'd0; in_use_imm = 1'b0;
    flush = 1'b0; wb_en = 1'b0; wb_rd = 4'd0; wb_data = 16'd0;
    out_ready = 1'b1; ovfl_clr = 1'b0;
    #2;
    chk("rst_async_in_ready", 16'(in_ready), 16'd1);
    chk("rst_async_out_valid", 16'(out_valid), 16'd0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single-instruction vectors; rd=0 keeps each result out of the next one's forwarding.
    for (int i = 0; i < 13; i++) begin
      cyc();
      issue(tbl[i].ctrl, 4'd1, 4'd2, 4'd0, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].use_imm);
      cyc();
      idle();
      cyc();
      #2;
      chk($sformatf("tbl%0d_valid", i), 16'(out_valid), 16'd1);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_ovfl", i), 16'(out_ovfl), 16'(tbl[i].exp_ovfl));
    end

    // Overflow and sticky, issued on the first edge after reset release.
    cyc();
    do_reset();
    issue(5'd0, 4'd1, 4'd2, 4'd3, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);
    cyc();
    idle();
    cyc();
    #2;
    chk("ovf_valid", 16'(out_valid), 16'd1);
    chk("ovf_data", out_data, 16'h8000);
    chk("ovf_flag", 16'(out_ovfl), 16'd1);
    chk("ovf_sticky", 16'(ovfl_sticky), 16'd1);

    // S2 forwarding with a stale register-file read.
    cyc();
    do_reset();
    issue(5'd0, 4'd1, 4'd2, 4'd3, 16'd5, 16'd7, 16'd0, 1'b0);
    cyc();
    issue(5'd1, 4'd3, 4'd1, 4'd4, 16'd0, 16'd5, 16'd0, 1'b0);
    cyc();
    idle();
    #2;
    chk("fwd_first", out_data, 16'h000C);
    cyc();
    #2;
    chk("fwd_second", out_data, 16'h0007);
    chk("fwd_second_rd", 16'(out_rd), 16'd4);

    // Backpressure: two instructions, result register blocked three cycles.
    cyc();
    do_reset();
    out_ready = 1'b0;
    issue(5'd0, 4'd6, 4'd7, 4'd5, 16'd1, 16'd2, 16'd0, 1'b0);
    cyc();
    issue(5'd4, 4'd9, 4'd10, 4'd8, 16'hF0F0, 16'h0FF0, 16'd0, 1'b0);
    cyc();
    idle();
    #2;
    chk("bp_in_ready", 16'(in_ready), 16'd0);
    chk("bp_hold0", out_data, 16'h0003);
    cyc();
    #2;
    chk("bp_hold1", out_data, 16'h0003);
    cyc();
    #2;
    chk("bp_hold2", out_data, 16'h0003);
    chk("bp_hold2_valid", 16'(out_valid), 16'd1);
    out_ready = 1'b1;
    cyc();
    #2;
    chk("bp_second", out_data, 16'hFF00);
    chk("bp_second_rd", 16'(out_rd), 16'd8);
    cyc();
    #2;
    chk("bp_drained", 16'(out_valid), 16'd0);

    // Flush with S1 full: the result must never appear.
    cyc();
    do_reset();
    issue(5'd0, 4'd1, 4'd2, 4'd2, 16'd10, 16'd20, 16'd0, 1'b0);
    cyc();
    idle();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #2;
    chk("flush_valid0", 16'(out_valid), 16'd0);
    chk("flush_in_ready", 16'(in_ready), 16'd1);
    cyc();
    #2;
    chk("flush_valid1", 16'(out_valid), 16'd0);

    // Register 0 ignores writeback forwarding; a nonzero index takes it.
    wb_en = 1'b1; wb_rd = 4'd0; wb_data = 16'h1111;
    issue(5'd0, 4'd0, 4'd0, 4'd5, 16'd3, 16'd4, 16'd0, 1'b0);
    cyc();
    idle();
    #2;
    chk("zero_alu_a", alu_a, 16'd3);
    chk("zero_alu_b", alu_b, 16'd4);
    cyc();
    #2;
    chk("zero_result", out_data, 16'd7);
    wb_rd = 4'd6;
    issue(5'd0, 4'd6, 4'd0, 4'd9, 16'd3, 16'd4, 16'd0, 1'b0);
    cyc();
    idle();
    cyc();
    #2;
    chk("wb_fwd_result", out_data, 16'h1115);
    wb_en = 1'b0;

    // Same-edge overflow and clear: set wins, clear applies one edge later.
    cyc();
    do_reset();
    issue(5'd0, 4'd1, 4'd2, 4'd3, 16'h7FFF, 16'h0001, 16'd0, 1'b0);
    cyc();
    idle();
    ovfl_clr = 1'b1;
    cyc();
    #2;
    chk("clr_set_wins", 16'(ovfl_sticky), 16'd1);
    cyc();
    ovfl_clr = 1'b0;
    #2;
    chk("clr_applied", 16'(ovfl_sticky), 16'd0);

    // Reset mid-stream with both stages occupied.
    issue(5'd0, 4'd1, 4'd2, 4'd3, 16'd1, 16'd1, 16'd0, 1'b0);
    cyc();
    issue(5'd0, 4'd1, 4'd2, 4'd4, 16'd2, 16'd2, 16'd0, 1'b0);
    cyc();
    idle();
    #2;
    chk("pre_rst_valid", 16'(out_valid), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
    chk("mid_rst_data", out_data, 16'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    #2;
    chk("no_replay", 16'(out_valid), 16'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n      = ($urandom_range(0, 499) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_ctrl    = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(10, 31))
                                                : 5'($urandom_range(0, 9));
      in_rs_a    = 4'($urandom_range(0, 7));
      in_rs_b    = 4'($urandom_range(0, 7));
      in_rd      = 4'($urandom_range(0, 7));
      in_a       = 16'($urandom);
      in_b       = 16'($urandom);
      in_imm     = 16'($urandom);
      in_use_imm = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      wb_en      = ($urandom_range(0, 1) == 0);
      wb_rd      = 4'($urandom_range(0, 7));
      wb_data    = 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      ovfl_clr   = ($urandom_range(0, 7) == 0);
    end

    cyc();
    rst_n = 1'b1; idle(); flush = 1'b0; out_ready = 1'b1; ovfl_clr = 1'b0;
    repeat (4) cyc();
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
